dmem_mmio_uart: RTL

//  Sits on the processor's data-memory port, between the processor and data RAM.

---
 rtl/dmem_mmio_uart_pkg.sv | 38 +++
 rtl/dmem_mmio_uart_if.sv | 31 +++
 rtl/dmem_mmio_uart_fifo_sync.sv | 56 +++++
 rtl/dmem_mmio_uart.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_uart_pkg.sv
// Shared definitions for the data-memory MMIO UART slice: default MMIO
// addresses, status word layout, serializer state encodings and a helper
// that assembles the status word.
package dmem_mmio_uart_pkg;

   localparam logic [31:0] TX_ADDR_DEFAULT   = 32'd4096;
   localparam logic [31:0] STAT_ADDR_DEFAULT = 32'd4097;

   localparam int STAT_FULL_BIT   = 0;
   localparam int STAT_EMPTY_BIT  = 1;
   localparam int STAT_ACTIVE_BIT = 2;
   localparam int STAT_OVF_BIT    = 3;
   localparam int STAT_COUNT_LSB  = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Status word: flags in the low nibble, FIFO occupancy in bits [15:8].
   function automatic logic [31:0] packStat(input logic       full,
                                            input logic       empty,
                                            input logic       active,
                                            input logic       overflow,
                                            input logic [7:0] count);
      logic [31:0] word;
      word                          = '0;
      word[STAT_FULL_BIT]           = full;
      word[STAT_EMPTY_BIT]          = empty;
      word[STAT_ACTIVE_BIT]         = active;
      word[STAT_OVF_BIT]            = overflow;
      word[STAT_COUNT_LSB +: 8]     = count;
      return word;
   endfunction

endpackage

// File: rtl/dmem_mmio_uart_if.sv
// Processor data-memory port as seen by the MMIO decoder. The master side is
// the processor together with the data RAM read port; the slave side is the
// decoder, which gates the RAM write enable and muxes the load data.
interface dmem_mmio_uart_if;

   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_ram;
   logic        wren_ram;
   logic [31:0] q_dmem;

   modport master (
      output address_dmem,
      output data,
      output wren,
      output q_ram,
      input  wren_ram,
      input  q_dmem
   );

   modport slave (
      input  address_dmem,
      input  data,
      input  wren,
      input  q_ram,
      output wren_ram,
      output q_dmem
   );

endinterface

// File: rtl/dmem_mmio_uart_fifo_sync.sv
// Generic synchronous FIFO with extra-MSB pointers. Kept free of UART
// specifics so the same block can serve a receive path later.
module dmem_mmio_uart_fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doPush;
   logic             doPop;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign count_o = wrPtr_q - rdPtr_q;
   assign dout_o  = mem_q[rdPtr_q[AW-1:0]];

   // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
   always_comb begin
      doPush  = push_i && (!full_o || pop_i);
      doPop   = pop_i && !empty_o;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/dmem_mmio_uart.sv
// Data-memory MMIO decoder with a UART transmitter. Two word addresses are
// claimed for the UART (TX data and status); everything else passes straight
// through to the data RAM with no added latency.
module dmem_mmio_uart
   import dmem_mmio_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
   parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   dmem_mmio_uart_if.slave bus,
   output logic            uart_tx,
   output logic            tx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   logic            txHit;
   logic            statHit;
   logic            pushReq;
   logic            statWrite;
   logic            fifoPop;
   logic            fifoFull;
   logic            fifoEmpty;
   logic [7:0]      fifoDout;
   logic [AW:0]     fifoCount;
   logic            overflow_q, overflow_d;
   tx_state_e       state_q, state_d;
   logic [CW-1:0]   bitCnt_q, bitCnt_d;
   logic [2:0]      bitIdx_q, bitIdx_d;
   logic [7:0]      shiftReg_q, shiftReg_d;
   logic            unusedDataHi;

   assign txHit        = (bus.address_dmem == TX_ADDR);
   assign statHit      = (bus.address_dmem == STAT_ADDR);
   assign pushReq      = bus.wren && txHit;
   assign statWrite    = bus.wren && statHit;
   assign bus.wren_ram = bus.wren && !(txHit || statHit);
   assign tx_busy      = !fifoEmpty || (state_q != TX_IDLE);
   assign unusedDataHi = ^bus.data[31:8];

   dmem_mmio_uart_fifo_sync #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (pushReq),
      .pop_i   (fifoPop),
      .din_i   (bus.data[7:0]),
      .dout_o  (fifoDout),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   // Load mux: status word, zero for the write-only TX register, RAM otherwise.
   always_comb begin
      bus.q_dmem = bus.q_ram;
      if (statHit) begin
         bus.q_dmem = packStat(fifoFull, fifoEmpty, state_q != TX_IDLE,
                               overflow_q, 8'(fifoCount));
      end else if (txHit) begin
         bus.q_dmem = 32'h0;
      end
   end

   // Sticky overflow: a dropped byte sets it, a status write clears it, set wins a tie.
   always_comb begin
      overflow_d = overflow_q;
      if (statWrite) overflow_d = 1'b0;
      if (pushReq && fifoFull && !fifoPop) overflow_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge clock) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   // Serializer next state: 8N1 framing, the stop bit pops the next byte so frames abut.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      bitIdx_d   = bitIdx_q;
      shiftReg_d = shiftReg_q;
      fifoPop    = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            bitCnt_d = '0;
            bitIdx_d = '0;
            if (!fifoEmpty) begin
               fifoPop    = 1'b1;
               shiftReg_d = fifoDout;
               state_d    = TX_START;
            end
         end
         TX_START: begin
            if (bitCnt_q == BIT_LAST) begin
               bitCnt_d = '0;
               bitIdx_d = '0;
               state_d  = TX_DATA;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (bitCnt_q == BIT_LAST) begin
               bitCnt_d = '0;
               if (bitIdx_q == 3'd7) begin
                  state_d = TX_STOP;
               end else begin
                  bitIdx_d   = bitIdx_q + 3'd1;
                  shiftReg_d = {1'b0, shiftReg_q[7:1]};
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (bitCnt_q == BIT_LAST) begin
               bitCnt_d = '0;
               if (!fifoEmpty) begin
                  fifoPop    = 1'b1;
                  shiftReg_d = fifoDout;
                  state_d    = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Serializer registers; reset abandons any frame in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= TX_IDLE;
         bitCnt_q   <= '0;
         bitIdx_q   <= '0;
         shiftReg_q <= '0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         bitIdx_q   <= bitIdx_d;
         shiftReg_q <= shiftReg_d;
      end
   end

   // Line level follows the current state; idle and stop are mark (high).
   always_comb begin
      uart_tx = 1'b1;
      unique case (state_q)
         TX_START: uart_tx = 1'b0;
         TX_DATA:  uart_tx = shiftReg_q[0];
         default:  uart_tx = 1'b1;
      endcase
   end

endmodule
